// File: rtl/nios_system_pio_pkg.sv
// Shared definitions for the parametrised input PIO.
//   - Word addresses of the Avalon-MM register map.
//   - clog2 helper used to size the per-bit debounce counters.
package nios_system_pio_pkg;

  localparam logic [2:0] ADDR_DATA         = 3'd0;
  localparam logic [2:0] ADDR_RAW          = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK     = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAPTURE = 3'd3;
  localparam logic [2:0] ADDR_RISE_EN      = 3'd4;
  localparam logic [2:0] ADDR_FALL_EN      = 3'd5;

  // Smallest r with 2**r >= value; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/nios_system_pio_in_ext_if.sv
// Avalon-MM slave bus of the input PIO plus its interrupt line.
//   address    : word register select
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data (only the low WIDTH bits are used by the slave)
//   readdata   : registered read data
//   irq        : level interrupt to the processor
interface nios_system_pio_in_ext_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );

endinterface

// File: rtl/nios_system_pio_debounce.sv
// One input bit: synchroniser chain followed by a stability filter.
//   clk, reset : system clock, asynchronous active-high reset
//   in_bit     : asynchronous board input
//   raw        : synchroniser output
//   q          : filtered (debounced) value
module nios_system_pio_debounce
  import nios_system_pio_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic in_bit,
  output logic raw,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   q_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], in_bit};
  end

  assign raw = sync_q[SYNC_STAGES-1];
  assign q   = q_q;

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    always_ff @(posedge clk or posedge reset) begin
      if (reset) q_q <= 1'b0;
      else       q_q <= raw;
    end
  end else begin : g_filter
    localparam int unsigned CntW = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            q_next;

    // Any return to the held value restarts the stability count.
    always_comb begin
      cnt_d  = cnt_q;
      q_next = q_q;
      if (raw == q_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntLast) begin
        q_next = raw;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
        q_q   <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        q_q   <= q_next;
      end
    end
  end

endmodule

// File: rtl/nios_system_pio_in_ext.sv
// Parametrised Avalon-MM input PIO with synchroniser, debounce, selectable edge
// detection, write-1-to-clear edge capture and masked level interrupt.
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : Avalon-MM slave (address/chipselect/write_n/writedata/readdata) + irq
//   in_port    : asynchronous board inputs
module nios_system_pio_in_ext
  import nios_system_pio_pkg::*;
#(
  parameter int unsigned      WIDTH           = 8,
  parameter int unsigned      SYNC_STAGES     = 2,
  parameter int unsigned      DEBOUNCE_CYCLES = 0,
  parameter logic [WIDTH-1:0] RISE_RESET      = '1,
  parameter logic [WIDTH-1:0] FALL_RESET      = '1
) (
  input  logic                    clk,
  input  logic                    reset,
  nios_system_pio_in_ext_if.slave bus,
  input  logic [WIDTH-1:0]        in_port
);

  logic [WIDTH-1:0] raw, q;
  logic [WIDTH-1:0] q_d_q;
  logic [WIDTH-1:0] irq_mask_q, rise_en_q, fall_en_q;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic [WIDTH-1:0] edge_det, clr;
  logic [WIDTH-1:0] wdata;
  logic [31:0]      rd_mux, readdata_q;
  logic             wr_en;
  logic             unused_writedata;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    nios_system_pio_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .in_bit(in_port[i]),
      .raw   (raw[i]),
      .q     (q[i])
    );
  end

  assign wr_en            = bus.chipselect & ~bus.write_n;
  assign wdata            = bus.writedata[WIDTH-1:0];
  assign unused_writedata = ^bus.writedata;

  assign edge_det = (rise_en_q & q & ~q_d_q) | (fall_en_q & ~q & q_d_q);

  // Clear first, then OR in new edges so a coincident edge keeps the bit set.
  always_comb begin
    clr = '0;
    if (wr_en && bus.address == ADDR_EDGE_CAPTURE) clr = wdata;
    edge_capture_d = (edge_capture_q & ~clr) | edge_det;
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_DATA:         rd_mux[WIDTH-1:0] = q;
      ADDR_RAW:          rd_mux[WIDTH-1:0] = raw;
      ADDR_IRQ_MASK:     rd_mux[WIDTH-1:0] = irq_mask_q;
      ADDR_EDGE_CAPTURE: rd_mux[WIDTH-1:0] = edge_capture_q;
      ADDR_RISE_EN:      rd_mux[WIDTH-1:0] = rise_en_q;
      ADDR_FALL_EN:      rd_mux[WIDTH-1:0] = fall_en_q;
      default:           rd_mux            = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_d_q          <= '0;
      irq_mask_q     <= '0;
      rise_en_q      <= RISE_RESET;
      fall_en_q      <= FALL_RESET;
      edge_capture_q <= '0;
      readdata_q     <= '0;
    end else begin
      q_d_q          <= q;
      edge_capture_q <= edge_capture_d;
      readdata_q     <= rd_mux;
      if (wr_en) begin
        case (bus.address)
          ADDR_IRQ_MASK: irq_mask_q <= wdata;
          ADDR_RISE_EN:  rise_en_q  <= wdata;
          ADDR_FALL_EN:  fall_en_q  <= wdata;
          default: ;
        endcase
      end
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_nios_system_pio_in_ext.sv
module tb_nios_system_pio_in_ext;
  import nios_system_pio_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  addr = '0;
  logic [2:0]  cs = '0;
  logic        wn = 1'b1;
  logic [31:0] wdata = '0;
  logic [7:0]  in8 = '0;
  logic [7:0]  indb = '0;
  logic [31:0] in32 = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nios_system_pio_in_ext_if b8 ();
  nios_system_pio_in_ext_if bdb ();
  nios_system_pio_in_ext_if b32 ();

  assign b8.address  = addr;
  assign b8.chipselect = cs[0];
  assign b8.write_n  = wn;
  assign b8.writedata = wdata;
  assign bdb.address = addr;
  assign bdb.chipselect = cs[1];
  assign bdb.write_n = wn;
  assign bdb.writedata = wdata;
  assign b32.address = addr;
  assign b32.chipselect = cs[2];
  assign b32.write_n = wn;
  assign b32.writedata = wdata;

  nios_system_pio_in_ext #(
    .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0)
  ) u_w8 (
    .clk(clk), .reset(reset), .bus(b8), .in_port(in8)
  );

  nios_system_pio_in_ext #(
    .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
  ) u_db (
    .clk(clk), .reset(reset), .bus(bdb), .in_port(indb)
  );

  nios_system_pio_in_ext #(
    .WIDTH(32), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(0)
  ) u_w32 (
    .clk(clk), .reset(reset), .bus(b32), .in_port(in32)
  );

  typedef struct {
    int          sel;
    bit          do_wr;
    logic [2:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] rdat(input int sel);
    case (sel)
      0:       return b8.readdata;
      1:       return bdb.readdata;
      default: return b32.readdata;
    endcase
  endfunction

  function automatic logic irq_of(input int sel);
    case (sel)
      0:       return b8.irq;
      1:       return bdb.irq;
      default: return b32.irq;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input int sel, input logic [2:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wn    = 1'b0;
    cs    = 3'b001 << sel;
    tick(1);
    cs    = '0;
    wn    = 1'b1;
  endtask

  task automatic rd(input int sel, input logic [2:0] a, output logic [31:0] v);
    addr = a;
    tick(1);
    v = rdat(sel);
  endtask

  logic [31:0] v;

  initial begin
    // Reset state: read map of every instance while inputs are 0.
    tick(3);
    chk("irq_in_reset", {31'd0, b8.irq}, 32'd0);
    chk("readdata_in_reset", b8.readdata, 32'd0);
    reset = 1'b0;

    vecs.push_back('{0, 0, 3'd0, 0, 32'h00});
    vecs.push_back('{0, 0, 3'd1, 0, 32'h00});
    vecs.push_back('{0, 0, 3'd2, 0, 32'h00});
    vecs.push_back('{0, 0, 3'd3, 0, 32'h00});
    vecs.push_back('{0, 0, 3'd4, 0, 32'hFF});
    vecs.push_back('{0, 0, 3'd5, 0, 32'hFF});
    vecs.push_back('{0, 0, 3'd6, 0, 32'h00});
    vecs.push_back('{0, 0, 3'd7, 0, 32'h00});
    vecs.push_back('{1, 0, 3'd4, 0, 32'hFF});
    vecs.push_back('{2, 0, 3'd4, 0, 32'hFFFF_FFFF});
    vecs.push_back('{2, 0, 3'd5, 0, 32'hFFFF_FFFF});
    // Register write/readback on the 8-bit instance.
    vecs.push_back('{0, 1, 3'd2, 32'h5A, 32'h5A});
    vecs.push_back('{0, 1, 3'd2, 32'hFFFF_FF3C, 32'h3C});
    vecs.push_back('{0, 1, 3'd4, 32'h0F, 32'h0F});
    vecs.push_back('{0, 1, 3'd5, 32'hF0, 32'hF0});
    vecs.push_back('{0, 1, 3'd0, 32'hFF, 32'h00});
    vecs.push_back('{0, 1, 3'd1, 32'hFF, 32'h00});
    vecs.push_back('{0, 1, 3'd6, 32'hFF, 32'h00});
    vecs.push_back('{0, 1, 3'd3, 32'hFF, 32'h00});
    vecs.push_back('{0, 1, 3'd4, 32'hFF, 32'hFF});
    vecs.push_back('{0, 1, 3'd5, 32'hFF, 32'hFF});
    vecs.push_back('{0, 1, 3'd2, 32'h00, 32'h00});

    foreach (vecs[i]) begin
      if (vecs[i].do_wr) wr(vecs[i].sel, vecs[i].a, vecs[i].d);
      rd(vecs[i].sel, vecs[i].a, v);
      chk($sformatf("vec%0d_sel%0d_addr%0d", i, vecs[i].sel, vecs[i].a), v, vecs[i].exp);
    end
    chk("irq_idle", {31'd0, b8.irq}, 32'd0);

    // 8-bit, no filter: DATA after 3 edges, capture and irq one edge later.
    wr(0, ADDR_IRQ_MASK, 32'h04);
    addr = ADDR_DATA;
    in8  = 8'h05;
    tick(3);
    chk("data_before_edge4", rdat(0), 32'h00);
    chk("irq_before_capture", {31'd0, irq_of(0)}, 32'd0);
    tick(1);
    chk("data_after_edge4", rdat(0), 32'h05);
    chk("irq_after_capture", {31'd0, irq_of(0)}, 32'd1);
    rd(0, ADDR_EDGE_CAPTURE, v);
    chk("capture_05", v, 32'h05);
    wr(0, ADDR_EDGE_CAPTURE, 32'h04);
    chk("irq_after_w1c", {31'd0, irq_of(0)}, 32'd0);
    rd(0, ADDR_EDGE_CAPTURE, v);
    chk("capture_after_w1c", v, 32'h01);
    wr(0, ADDR_EDGE_CAPTURE, 32'hFF);
    wr(0, ADDR_IRQ_MASK, 32'h00);

    // Edge selection: fall-only on bit 0.
    wr(0, ADDR_RISE_EN, 32'h00);
    wr(0, ADDR_FALL_EN, 32'h00);
    in8 = 8'h04;
    tick(5);
    rd(0, ADDR_EDGE_CAPTURE, v);
    chk("no_capture_disabled", v, 32'h00);
    wr(0, ADDR_FALL_EN, 32'h01);
    in8 = 8'h05;
    tick(5);
    rd(0, ADDR_EDGE_CAPTURE, v);
    chk("rise_ignored", v, 32'h00);
    in8 = 8'h04;
    tick(5);
    rd(0, ADDR_EDGE_CAPTURE, v);
    chk("fall_captured", v, 32'h01);
    wr(0, ADDR_RISE_EN, 32'hFF);
    rd(0, ADDR_EDGE_CAPTURE, v);
    chk("capture_kept_on_en_change", v, 32'h01);
    wr(0, ADDR_EDGE_CAPTURE, 32'hFF);
    wr(0, ADDR_FALL_EN, 32'hFF);
    rd(0, ADDR_EDGE_CAPTURE, v);
    chk("capture_cleared", v, 32'h00);

    // W1C in the same cycle bit 1's edge is captured: set wins.
    in8 = 8'h06;
    tick(3);
    wr(0, ADDR_EDGE_CAPTURE, 32'h02);
    rd(0, ADDR_EDGE_CAPTURE, v);
    chk("w1c_collision_set_wins", v, 32'h02);
    wr(0, ADDR_EDGE_CAPTURE, 32'h02);
    rd(0, ADDR_EDGE_CAPTURE, v);
    chk("w1c_after_collision", v, 32'h00);

    // Debounce of 4: short pulse rejected, long pulse accepted once.
    addr = ADDR_DATA;
    indb = 8'h01;
    tick(3);
    indb = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk($sformatf("db_pulse_rejected_%0d", i), rdat(1), 32'h00);
    end
    rd(1, ADDR_EDGE_CAPTURE, v);
    chk("db_no_capture_short", v, 32'h00);
    addr = ADDR_DATA;
    indb = 8'h01;
    tick(6);
    chk("db_data_edge6", rdat(1), 32'h00);
    tick(1);
    chk("db_data_edge7", rdat(1), 32'h01);
    tick(4);
    rd(1, ADDR_EDGE_CAPTURE, v);
    chk("db_capture_once", v, 32'h01);
    wr(1, ADDR_EDGE_CAPTURE, 32'h01);
    tick(5);
    rd(1, ADDR_EDGE_CAPTURE, v);
    chk("db_no_second_capture", v, 32'h00);

    // 32-bit, three sync stages.
    addr = ADDR_DATA;
    in32 = 32'hDEAD_BEEF;
    tick(4);
    chk("w32_data_edge4", rdat(2), 32'h0);
    tick(1);
    chk("w32_data_edge5", rdat(2), 32'hDEAD_BEEF);
    rd(2, ADDR_RAW, v);
    chk("w32_raw", v, 32'hDEAD_BEEF);
    rd(2, 3'd7, v);
    chk("w32_addr7", v, 32'h0);
    wr(2, ADDR_IRQ_MASK, 32'hFFFF_FFFF);
    chk("w32_irq", {31'd0, irq_of(2)}, 32'd1);
    rd(2, ADDR_EDGE_CAPTURE, v);
    chk("w32_capture", v, 32'hDEAD_BEEF);

    // Reset asserted mid-debounce on the filtered instance.
    addr = ADDR_DATA;
    indb = 8'h00;
    tick(3);
    reset = 1'b1;
    #1;
    chk("rst_async_w32_readdata", rdat(2), 32'h0);
    chk("rst_async_w32_irq", {31'd0, irq_of(2)}, 32'd0);
    chk("rst_async_db_readdata", rdat(1), 32'h0);
    tick(2);
    reset = 1'b0;
    rd(1, ADDR_DATA, v);
    chk("rst_db_data", v, 32'h0);
    rd(2, ADDR_IRQ_MASK, v);
    chk("rst_w32_mask", v, 32'h0);
    rd(2, ADDR_RISE_EN, v);
    chk("rst_w32_rise", v, 32'hFFFF_FFFF);
    rd(2, ADDR_EDGE_CAPTURE, v);
    chk("rst_w32_capture", v, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
